// File: rtl/hazard_stall_unit.sv
// Hazard stall unit for the 5-stage MIPS core.
// Combines Tuse/Tnew RAW detection with an MDU busy countdown into the single
// Stall_Data request, and keeps a saturating count of stalled cycles for profiling.
module hazard_stall_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4:0]             D_rs_addr,
    input  logic [4:0]             D_rt_addr,
    input  logic [1:0]             D_tuse_rs,
    input  logic [1:0]             D_tuse_rt,
    input  logic                   D_is_md,
    input  logic [4:0]             E_wa,
    input  logic [1:0]             E_tnew,
    input  logic [4:0]             M_wa,
    input  logic [1:0]             M_tnew,
    input  logic                   E_md_mult,
    input  logic                   E_md_div,
    output logic                   Stall_Data,
    output logic                   md_busy,
    output logic                   md_done,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [3:0] MultLoad = 4'(MULT_CYCLES);
    localparam logic [3:0] DivLoad  = 4'(DIV_CYCLES);
    localparam logic [STALL_CNT_W-1:0] CntOne = STALL_CNT_W'(1);

    logic [3:0]             cnt_q, cnt_d;
    logic                   md_done_q, md_done_d;
    logic [STALL_CNT_W-1:0] stall_count_q, stall_count_d;

    logic rs_hit, rt_hit, md_stall, md_start;

    // RAW and MDU stall detection; a Tuse of 3 can never be below any Tnew (max 2).
    always_comb begin
        rs_hit = (D_rs_addr != 5'd0) &&
                 (((D_rs_addr == E_wa) && (D_tuse_rs < E_tnew)) ||
                  ((D_rs_addr == M_wa) && (D_tuse_rs < M_tnew)));
        rt_hit = (D_rt_addr != 5'd0) &&
                 (((D_rt_addr == E_wa) && (D_tuse_rt < E_tnew)) ||
                  ((D_rt_addr == M_wa) && (D_tuse_rt < M_tnew)));
        md_start   = E_md_mult || E_md_div;
        md_stall   = D_is_md && (md_busy || md_start);
        Stall_Data = !reset && (rs_hit || rt_hit || md_stall);
    end

    // Countdown next state: newest start reloads, div load beats mult load.
    always_comb begin
        cnt_d = cnt_q;
        if (E_md_div) begin
            cnt_d = DivLoad;
        end else if (E_md_mult) begin
            cnt_d = MultLoad;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        // Expiry pulse only when the count runs out without being reloaded.
        md_done_d = (cnt_q == 4'd1) && !md_start;
    end

    // Saturating stall-cycle counter next state.
    always_comb begin
        stall_count_d = stall_count_q;
        if (Stall_Data && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CntOne;
        end
    end

    // State registers with synchronous reset; reset aborts any countdown silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= 4'd0;
            md_done_q     <= 1'b0;
            stall_count_q <= '0;
        end else begin
            cnt_q         <= cnt_d;
            md_done_q     <= md_done_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign md_busy     = (cnt_q != 4'd0);
    assign md_done     = md_done_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit.
// Inputs change 1 time unit after posedge; outputs are sampled on negedge.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  D_rs_addr, D_rt_addr, E_wa, M_wa;
    logic [1:0]  D_tuse_rs, D_tuse_rt, E_tnew, M_tnew;
    logic        D_is_md, E_md_mult, E_md_div;

    logic        stall, busy, done;
    logic [31:0] scnt;
    logic        stall_s, busy_s, done_s;
    logic [3:0]  scnt_s;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_stall_unit u_dut (
        .clk        (clk),
        .reset      (reset),
        .D_rs_addr  (D_rs_addr),
        .D_rt_addr  (D_rt_addr),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .D_is_md    (D_is_md),
        .E_wa       (E_wa),
        .E_tnew     (E_tnew),
        .M_wa       (M_wa),
        .M_tnew     (M_tnew),
        .E_md_mult  (E_md_mult),
        .E_md_div   (E_md_div),
        .Stall_Data (stall),
        .md_busy    (busy),
        .md_done    (done),
        .stall_count(scnt)
    );

    hazard_stall_unit #(.STALL_CNT_W(4)) u_dut_sat (
        .clk        (clk),
        .reset      (reset),
        .D_rs_addr  (D_rs_addr),
        .D_rt_addr  (D_rt_addr),
        .D_tuse_rs  (D_tuse_rs),
        .D_tuse_rt  (D_tuse_rt),
        .D_is_md    (D_is_md),
        .E_wa       (E_wa),
        .E_tnew     (E_tnew),
        .M_wa       (M_wa),
        .M_tnew     (M_tnew),
        .E_md_mult  (E_md_mult),
        .E_md_div   (E_md_div),
        .Stall_Data (stall_s),
        .md_busy    (busy_s),
        .md_done    (done_s),
        .stall_count(scnt_s)
    );

    task automatic idle_inputs();
        D_rs_addr = 5'd0; D_rt_addr = 5'd0;
        D_tuse_rs = 2'd3; D_tuse_rt = 2'd3;
        D_is_md   = 1'b0;
        E_wa = 5'd0; E_tnew = 2'd0;
        M_wa = 5'd0; M_tnew = 2'd0;
        E_md_mult = 1'b0; E_md_div = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        D_is_md = 1'b1; E_md_mult = 1'b1;
        D_rs_addr = 5'd8; D_tuse_rs = 2'd0; E_wa = 5'd8; E_tnew = 2'd2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (stall !== 1'b0) begin
                errors++; $display("FAIL reset_stall c%0d got %b exp 0", c, stall);
            end
            if (c > 0) begin
                checks++;
                if (busy !== 1'b0 || done !== 1'b0 || scnt !== 32'd0) begin
                    errors++;
                    $display("FAIL reset_state c%0d got busy=%b done=%b cnt=%0d exp 0/0/0",
                             c, busy, done, scnt);
                end
            end
            next_cycle();
        end
        idle_inputs();
        reset = 1'b0;
    endtask

    task automatic test_raw();
        logic [4:0] t_rs [9]  = '{5'd8, 5'd8, 5'd0, 5'd0, 5'd8, 5'd9, 5'd9, 5'd7,  5'd7};
        logic [1:0] t_trs[9]  = '{2'd1, 2'd1, 2'd0, 2'd3, 2'd3, 2'd1, 2'd0, 2'd3,  2'd0};
        logic [4:0] t_rt [9]  = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd12, 5'd7};
        logic [1:0] t_trt[9]  = '{2'd3, 2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3, 2'd1,  2'd0};
        logic [4:0] t_ewa[9]  = '{5'd8, 5'd8, 5'd0, 5'd0, 5'd8, 5'd0, 5'd0, 5'd12, 5'd3};
        logic [1:0] t_etn[9]  = '{2'd2, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd0, 2'd2,  2'd2};
        logic [4:0] t_mwa[9]  = '{5'd0, 5'd0, 5'd0, 5'd5, 5'd0, 5'd9, 5'd9, 5'd0,  5'd3};
        logic [1:0] t_mtn[9]  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0,  2'd1};
        logic       t_exp[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,  1'b0};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            idle_inputs();
            D_rs_addr = t_rs[i]; D_tuse_rs = t_trs[i];
            D_rt_addr = t_rt[i]; D_tuse_rt = t_trt[i];
            E_wa = t_ewa[i]; E_tnew = t_etn[i];
            M_wa = t_mwa[i]; M_tnew = t_mtn[i];
            @(negedge clk);
            checks++;
            if (stall !== t_exp[i]) begin
                errors++; $display("FAIL raw_vec%0d got %b exp %b", i, stall, t_exp[i]);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (scnt !== 32'd4) begin
            errors++; $display("FAIL raw_stall_count got %0d exp 4", scnt);
        end
        next_cycle();
    endtask

    task automatic test_mdu_mult();
        logic eb, ed, es;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            D_is_md   = 1'b1;
            E_md_mult = (c == 0);
            eb = (c >= 1 && c <= 5);
            ed = (c == 6);
            es = (c <= 5);
            @(negedge clk);
            checks++;
            if (stall !== es || busy !== eb || done !== ed) begin
                errors++;
                $display("FAIL mult_c%0d got stall=%b busy=%b done=%b exp %b/%b/%b",
                         c, stall, busy, done, es, eb, ed);
            end
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        checks++;
        if (scnt !== 32'd6) begin
            errors++; $display("FAIL mult_stall_count got %0d exp 6", scnt);
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic eb, ed;
        do_reset();
        for (int c = 0; c < 13; c++) begin
            E_md_mult = (c == 0);
            E_md_div  = (c == 0);
            eb = (c >= 1 && c <= 10);
            ed = (c == 11);
            @(negedge clk);
            checks++;
            if (busy !== eb || done !== ed) begin
                errors++;
                $display("FAIL both_c%0d got busy=%b done=%b exp %b/%b", c, busy, done, eb, ed);
            end
            next_cycle();
        end
        do_reset();
        for (int c = 0; c < 17; c++) begin
            E_md_mult = (c == 0);
            E_md_div  = (c == 3);
            eb = (c >= 1 && c <= 13);
            ed = (c == 14);
            @(negedge clk);
            checks++;
            if (busy !== eb || done !== ed) begin
                errors++;
                $display("FAIL reload_c%0d got busy=%b done=%b exp %b/%b", c, busy, done, eb, ed);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_reset_abort();
        logic es;
        do_reset();
        for (int c = 0; c < 17; c++) begin
            D_is_md  = 1'b1;
            E_md_div = (c == 0);
            reset    = (c == 4 || c == 5);
            es = (c <= 3);
            @(negedge clk);
            checks++;
            if (stall !== es || done !== 1'b0) begin
                errors++;
                $display("FAIL abort_c%0d got stall=%b done=%b exp %b/0", c, stall, done, es);
            end
            if (c == 4) begin
                checks++;
                if (scnt !== 32'd4 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_pre got cnt=%0d busy=%b exp 4/1", scnt, busy);
                end
            end
            if (c >= 5) begin
                checks++;
                if (busy !== 1'b0 || scnt !== 32'd0) begin
                    errors++;
                    $display("FAIL abort_post_c%0d got busy=%b cnt=%0d exp 0/0", c, busy, scnt);
                end
            end
            next_cycle();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    task automatic test_saturate();
        logic [3:0]  es;
        do_reset();
        for (int c = 0; c < 23; c++) begin
            idle_inputs();
            if (c < 20) begin
                D_rs_addr = 5'd8; D_tuse_rs = 2'd1; E_wa = 5'd8; E_tnew = 2'd2;
            end
            es = (c > 15) ? 4'd15 : 4'(c);
            @(negedge clk);
            checks++;
            if (scnt_s !== es || scnt !== 32'(c > 20 ? 20 : c)) begin
                errors++;
                $display("FAIL sat_c%0d got small=%0d wide=%0d exp %0d/%0d",
                         c, scnt_s, scnt, es, (c > 20 ? 20 : c));
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        next_cycle();
        test_reset();
        test_raw();
        test_mdu_mult();
        test_back_to_back();
        test_reset_abort();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
